// File: rtl/enc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enc_arb_pkg
// Brief    : Shared constants for enc_share_arbiter: datapath widths, FSM
//            state encoding and sweep length. SWEEP state exists only when
//            ENC_ARB_SWEEP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package enc_arb_pkg;

  localparam int DP_DATA_W = 4;
  localparam int DP_RES_W  = 3;
  localparam int SWEEP_OPS = 32;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_drive = 2'd1;
  localparam logic [1:0] c_st_resp  = 2'd2;
`ifdef ENC_ARB_SWEEP_EN
  localparam logic [1:0] c_st_sweep = 2'd3;
`endif

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker. Grants the first requester at
//            or after ptr, wrapping modulo NUM_REQ. One-hot grant plus index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  // Scan candidates in rotated order starting at ptr; first hit wins
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_valid && req[i] && (i == ((int'(ptr) + off) % NUM_REQ))) begin
          grant[i]    = 1'b1;
          grant_idx   = ID_W'(i);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/enc_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : enc_share_arbiter
// Brief    : Time-shares one 4-bit/1-bit -> 3-bit combinational datapath
//            among NUM_REQ requesters. Round-robin grant, operands held for
//            SETTLE_CYCLES, result returned with the requester id.
//            Optional self-sweep mode under macro ENC_ARB_SWEEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module enc_share_arbiter
  import enc_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_select,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [3:0]           dp_data,
  output logic                 dp_select,
  input  logic [2:0]           dp_out,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [2:0]           rsp_result,
  input  logic                 rsp_ready,
  output logic                 busy
`ifdef ENC_ARB_SWEEP_EN
  ,
  input  logic                 sweep_start,
  output logic                 sweep_done,
  output logic [2:0]           sweep_sig
`endif
);

  localparam logic [3:0]      c_settle_last = 4'(SETTLE_CYCLES - 1);
  localparam logic [ID_W-1:0] c_last_id     = ID_W'(NUM_REQ - 1);

  logic [1:0]           r_state;
  logic [ID_W-1:0]      r_ptr;
  logic [3:0]           r_cnt;
  logic [ID_W-1:0]      r_cur_id;
  logic [DP_DATA_W-1:0] r_dp_data;
  logic                 r_dp_select;
  logic                 r_rsp_valid;
  logic [ID_W-1:0]      r_rsp_id;
  logic [DP_RES_W-1:0]  r_rsp_result;

  logic [NUM_REQ-1:0]   w_grant;
  logic [ID_W-1:0]      w_grant_idx;
  logic                 w_grant_valid;
  logic [ID_W-1:0]      w_ptr_next;
  logic [DP_DATA_W-1:0] w_sel_data;
  logic                 w_sel_select;
  logic                 w_idle_open;

`ifdef ENC_ARB_SWEEP_EN
  localparam logic [4:0] c_sweep_last = 5'(SWEEP_OPS - 1);
  logic [4:0]          r_sweep_op;
  logic                r_sweep_done;
  logic [DP_RES_W-1:0] r_sweep_sig;
  logic [4:0]          w_op_next;
  assign w_op_next   = r_sweep_op + 5'd1;
  // A sweep request pre-empts requesters in the same IDLE cycle
  assign w_idle_open = (r_state == c_st_idle) && !sweep_start;
  assign sweep_done  = r_sweep_done;
  assign sweep_sig   = r_sweep_sig;
`else
  assign w_idle_open = (r_state == c_st_idle);
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req         (req_valid),
    .ptr         (r_ptr),
    .grant       (w_grant),
    .grant_idx   (w_grant_idx),
    .grant_valid (w_grant_valid)
  );

  assign w_ptr_next = (w_grant_idx == c_last_id) ? '0 : w_grant_idx + ID_W'(1);

  // Route the granted requester's operands toward the datapath registers
  always_comb begin
    w_sel_data   = '0;
    w_sel_select = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_data   = req_data[i*DP_DATA_W +: DP_DATA_W];
        w_sel_select = req_select[i];
      end
    end
  end

  assign req_ready  = w_idle_open ? w_grant : '0;
  assign dp_data    = r_dp_data;
  assign dp_select  = r_dp_select;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign busy       = (r_state != c_st_idle);

  // Main FSM: accept -> hold operands for the settle window -> respond
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_st_idle;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_cur_id     <= '0;
      r_dp_data    <= '0;
      r_dp_select  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
`ifdef ENC_ARB_SWEEP_EN
      r_sweep_op   <= '0;
      r_sweep_done <= 1'b0;
      r_sweep_sig  <= '0;
`endif
    end else begin
`ifdef ENC_ARB_SWEEP_EN
      r_sweep_done <= 1'b0;
`endif
      case (r_state)
        c_st_idle: begin
`ifdef ENC_ARB_SWEEP_EN
          if (sweep_start) begin
            r_state     <= c_st_sweep;
            r_cnt       <= '0;
            r_sweep_op  <= '0;
            r_sweep_sig <= '0;
            r_dp_data   <= '0;
            r_dp_select <= 1'b0;
          end else if (w_grant_valid) begin
`else
          if (w_grant_valid) begin
`endif
            r_state     <= c_st_drive;
            r_cnt       <= '0;
            r_dp_data   <= w_sel_data;
            r_dp_select <= w_sel_select;
            r_cur_id    <= w_grant_idx;
            r_ptr       <= w_ptr_next;
          end
        end
        c_st_drive: begin
          if (r_cnt == c_settle_last) begin
            r_rsp_result <= dp_out;
            r_rsp_id     <= r_cur_id;
            r_rsp_valid  <= 1'b1;
            r_state      <= c_st_resp;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        c_st_resp: begin
          if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= c_st_idle;
          end
        end
`ifdef ENC_ARB_SWEEP_EN
        c_st_sweep: begin
          if (r_cnt == c_settle_last) begin
            r_sweep_sig <= r_sweep_sig ^ dp_out;
            r_cnt       <= '0;
            if (r_sweep_op == c_sweep_last) begin
              r_state      <= c_st_idle;
              r_sweep_done <= 1'b1;
            end else begin
              // Op k drives data k/2 with select k%2
              r_sweep_op  <= w_op_next;
              r_dp_data   <= w_op_next[4:1];
              r_dp_select <= w_op_next[0];
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
`endif
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_enc_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_enc_share_arbiter
// Brief    : Directed self-checking bench. Instance A uses SETTLE_CYCLES=1,
//            instance B uses SETTLE_CYCLES=3 with a glitchable datapath stub.
//            Sweep scenario present only with ENC_ARB_SWEEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enc_share_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A signals
  logic [3:0]  a_req_valid, a_req_select, a_req_ready;
  logic [15:0] a_req_data;
  logic [3:0]  a_dp_data;
  logic        a_dp_select;
  logic [2:0]  a_dp_out;
  logic        a_rsp_valid, a_rsp_ready, a_busy;
  logic [1:0]  a_rsp_id;
  logic [2:0]  a_rsp_result;
  assign a_dp_out = {a_dp_select, a_dp_data[1:0]};

  // Instance B signals
  logic [3:0]  b_req_valid, b_req_select, b_req_ready;
  logic [15:0] b_req_data;
  logic [3:0]  b_dp_data;
  logic        b_dp_select;
  logic [2:0]  b_dp_out;
  logic        b_rsp_valid, b_rsp_ready, b_busy;
  logic [1:0]  b_rsp_id;
  logic [2:0]  b_rsp_result;
  logic        b_glitch;
  assign b_dp_out = {b_dp_select, b_dp_data[1:0]} ^ (b_glitch ? 3'b111 : 3'b000);

`ifdef ENC_ARB_SWEEP_EN
  logic       a_sweep_start, a_sweep_done, b_sweep_start, b_sweep_done;
  logic [2:0] a_sweep_sig, b_sweep_sig;
`endif

  enc_share_arbiter #(.NUM_REQ(4), .SETTLE_CYCLES(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_data(a_req_data), .req_select(a_req_select),
    .req_ready(a_req_ready), .dp_data(a_dp_data), .dp_select(a_dp_select),
    .dp_out(a_dp_out), .rsp_valid(a_rsp_valid), .rsp_id(a_rsp_id),
    .rsp_result(a_rsp_result), .rsp_ready(a_rsp_ready), .busy(a_busy)
`ifdef ENC_ARB_SWEEP_EN
    , .sweep_start(a_sweep_start), .sweep_done(a_sweep_done), .sweep_sig(a_sweep_sig)
`endif
  );

  enc_share_arbiter #(.NUM_REQ(4), .SETTLE_CYCLES(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_data(b_req_data), .req_select(b_req_select),
    .req_ready(b_req_ready), .dp_data(b_dp_data), .dp_select(b_dp_select),
    .dp_out(b_dp_out), .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id),
    .rsp_result(b_rsp_result), .rsp_ready(b_rsp_ready), .busy(b_busy)
`ifdef ENC_ARB_SWEEP_EN
    , .sweep_start(b_sweep_start), .sweep_done(b_sweep_done), .sweep_sig(b_sweep_sig)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Event log for instance A: grants (index, cycle) and handshaken responses
  int         cyc = 0;
  int         g_idx[$];
  int         g_cyc[$];
  logic [4:0] r_q[$];
  int         onehot_bad = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (!rst) begin
      if ($countones(a_req_ready) > 1) onehot_bad++;
      for (int i = 0; i < 4; i++) begin
        if (a_req_ready[i]) begin
          g_idx.push_back(i);
          g_cyc.push_back(cyc);
        end
      end
      if (a_rsp_valid && a_rsp_ready) r_q.push_back({a_rsp_id, a_rsp_result});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_rsp(input string tag);
    int k = 0;
    while (!a_rsp_valid && k < 20) begin
      step();
      k++;
    end
    check_val(tag, a_rsp_valid, 1);
  endtask

  task automatic wait_a_idle(input string tag);
    int k = 0;
    while (a_busy && k < 20) begin
      step();
      k++;
    end
    check_val(tag, a_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int bad;
    rst = 1'b1;
    a_req_valid = '0; a_req_data = '0; a_req_select = '0; a_rsp_ready = 1'b1;
    b_req_valid = '0; b_req_data = '0; b_req_select = '0; b_rsp_ready = 1'b1;
    b_glitch = 1'b0;
`ifdef ENC_ARB_SWEEP_EN
    a_sweep_start = 1'b0;
    b_sweep_start = 1'b0;
`endif
    #2;
    // Reset values
    check_val("rst_dp_data",    a_dp_data,    0);
    check_val("rst_dp_select",  a_dp_select,  0);
    check_val("rst_rsp_valid",  a_rsp_valid,  0);
    check_val("rst_rsp_id",     a_rsp_id,     0);
    check_val("rst_rsp_result", a_rsp_result, 0);
    check_val("rst_req_ready",  a_req_ready,  0);
    check_val("rst_busy",       a_busy,       0);
    step(); step();
    rst = 1'b0;
    step();

    // Reset asserted while an operation is in DRIVE
    a_req_data[3:0] = 4'hA; a_req_select[0] = 1'b1; a_req_valid = 4'b0001;
    step();
    a_req_valid = '0;
    check_val("md_busy",      a_busy,      1);
    check_val("md_dp_data",   a_dp_data,   4'hA);
    check_val("md_dp_select", a_dp_select, 1);
    #1 rst = 1'b1;
    #1;
    check_val("md_rst_dp_data",   a_dp_data,   0);
    check_val("md_rst_dp_select", a_dp_select, 0);
    check_val("md_rst_busy",      a_busy,      0);
    check_val("md_rst_rsp_valid", a_rsp_valid, 0);
    step();
    rst = 1'b0;
    repeat (3) step();
    check_val("md_no_rsp_valid", a_rsp_valid, 0);
    check_val("md_no_rsp_q",     r_q.size(),  0);
    g_idx.delete(); g_cyc.delete(); r_q.delete();

    // Round robin, all four valid; first grant 0 shows the pointer was reset
    for (int i = 0; i < 4; i++) a_req_data[i*4 +: 4] = 4'(i);
    a_req_select = 4'hF;
    a_req_valid  = 4'hF;
    k = 0;
    while (g_idx.size() < 5 && k < 60) begin
      step();
      k++;
    end
    a_req_valid = '0;
    check_val("rr_grant_count", g_idx.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < g_idx.size()) check_val($sformatf("rr_grant%0d", i), g_idx[i], i % 4);
    if (g_cyc.size() >= 2) check_val("rr_spacing", g_cyc[1] - g_cyc[0], 3);
    k = 0;
    while (r_q.size() < 5 && k < 20) begin
      step();
      k++;
    end
    check_val("rr_rsp_count", r_q.size(), 5);
    for (int i = 0; i < 4; i++)
      if (i < r_q.size()) check_val($sformatf("rr_rsp%0d", i), r_q[i], {2'(i), 1'b1, 2'(i)});
    wait_a_idle("rr_idle");
    g_idx.delete(); g_cyc.delete(); r_q.delete();

    // Single request from requester 1
    a_req_data[7:4] = 4'h6; a_req_select = 4'b0000; a_req_valid = 4'b0010;
    #1;
    check_val("sr_ready_comb", a_req_ready, 4'b0010);
    step();
    a_req_valid = '0;
    check_val("sr_ready_after", a_req_ready, 0);
    check_val("sr_rsp_early",   a_rsp_valid, 0);
    step();
    check_val("sr_rsp_valid",  a_rsp_valid,  1);
    check_val("sr_rsp_id",     a_rsp_id,     1);
    check_val("sr_rsp_result", a_rsp_result, 3'b010);
    repeat (3) step();
    check_val("sr_grant_count", g_idx.size(), 1);
    g_idx.delete(); g_cyc.delete(); r_q.delete();

    // Backpressure: requesters 2 and 3 pending, consumer stalls
    a_rsp_ready = 1'b0;
    a_req_data[11:8] = 4'h5; a_req_data[15:12] = 4'h3;
    a_req_select = 4'b0100;
    a_req_valid  = 4'b1100;
    step();
    a_req_valid = 4'b1000;
    wait_a_rsp("bp_rsp_arrives");
    for (int i = 0; i < 5; i++) begin
      check_val("bp_rsp_valid",  a_rsp_valid,  1);
      check_val("bp_rsp_id",     a_rsp_id,     2);
      check_val("bp_rsp_result", a_rsp_result, 3'b101);
      check_val("bp_req_ready",  a_req_ready,  0);
      step();
    end
    a_rsp_ready = 1'b1;
    step();
    check_val("bp_rsp_cleared", a_rsp_valid, 0);
    check_val("bp_next_grant",  a_req_ready, 4'b1000);
    step();
    a_req_valid = '0;
    wait_a_rsp("bp_rsp3_arrives");
    check_val("bp_rsp3_id",     a_rsp_id,     3);
    check_val("bp_rsp3_result", a_rsp_result, 3'b011);
    check_val("bp_grant_count", g_idx.size(), 2);
    wait_a_idle("bp_idle");

    // Settle window on instance B: glitch during the first two DRIVE cycles
    b_req_data[3:0] = 4'h2; b_req_select = 4'b0001; b_req_valid = 4'b0001;
    step();
    b_req_valid = '0;
    b_glitch = 1'b1;
    check_val("st_c1_dp_data",   b_dp_data,   4'h2);
    check_val("st_c1_rsp_valid", b_rsp_valid, 0);
    step();
    check_val("st_c2_dp_data",   b_dp_data,   4'h2);
    check_val("st_c2_rsp_valid", b_rsp_valid, 0);
    step();
    b_glitch = 1'b0;
    check_val("st_c3_dp_data",   b_dp_data,   4'h2);
    check_val("st_c3_rsp_valid", b_rsp_valid, 0);
    step();
    check_val("st_rsp_valid",  b_rsp_valid,  1);
    check_val("st_rsp_id",     b_rsp_id,     0);
    check_val("st_rsp_result", b_rsp_result, 3'b110);
    step();
    check_val("st_idle", b_busy, 0);

`ifdef ENC_ARB_SWEEP_EN
    // Sweep on instance A with a pending requester that must wait
    g_idx.delete(); g_cyc.delete(); r_q.delete();
    a_req_data[3:0] = 4'h1; a_req_select = 4'b0000; a_req_valid = 4'b0001;
    a_sweep_start = 1'b1;
    #1;
    check_val("sw_prio_ready", a_req_ready, 0);
    step();
    a_sweep_start = 1'b0;
    check_val("sw_busy", a_busy, 1);
    k = 1;
    bad = 0;
    while (!a_sweep_done && k < 100) begin
      if (a_req_ready != 4'b0000 || !a_busy) bad++;
      step();
      k++;
    end
    check_val("sw_done_seen",  a_sweep_done, 1);
    check_val("sw_done_cycle", k, 33);
    check_val("sw_sig",        a_sweep_sig, 3'b000);
    check_val("sw_ready_busy", bad, 0);
    step();
    check_val("sw_done_pulse", a_sweep_done, 0);
    a_req_valid = '0;
    wait_a_idle("sw_idle");
`endif

    check_val("onehot_ready", onehot_bad, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/enc_share_arbiter.md
Name: enc_share_arbiter

Overview:
Shares the single 4-bit-data / 1-bit-select / 3-bit-result combinational datapath (`top`) among NUM_REQ requesters. Each requester posts a (data, select) operation; the block arbitrates round-robin and drives the datapath. It holds the operands for a settle window, captures the 3-bit result, and returns it tagged with the requester id. It sits between requester logic and the `top` instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
SETTLE_CYCLES, 1, cycles operands are held on the datapath before result capture (1..15)
ID_W, $clog2(NUM_REQ), width of requester id

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester operation request
req_data  in  4*NUM_REQ  operand data; requester i uses bits [4i+3:4i]
req_select  in  NUM_REQ  operand select per requester
req_ready  out  NUM_REQ  accept strobe; one-hot or zero
dp_data  out  4  to datapath data
dp_select  out  1  to datapath select
dp_out  in  3  from datapath result
rsp_valid  out  1  response available
rsp_id  out  ID_W  id of requester the response belongs to
rsp_result  out  3  captured datapath result
rsp_ready  in  1  response consumer ready
busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-high. Outputs at reset: dp_data=0, dp_select=0, rsp_valid=0, rsp_id=0, rsp_result=0, req_ready=0, busy=0. The round-robin pointer resets to 0, so requester 0 has highest priority first.
- FSM states:
  - IDLE. If any req_valid is set, the grant goes to the first valid requester at or after the pointer, wrapping modulo NUM_REQ. req_ready[grant] is combinational: state==IDLE && grant. On that edge, the block latches the grant's data and select into dp_data/dp_select, latches the id, sets the pointer to grant+1 mod NUM_REQ, and moves to DRIVE. If no request is valid, it stays in IDLE and req_ready=0.
  - DRIVE. A settle counter runs from 0 to SETTLE_CYCLES-1. On the edge where the counter equals SETTLE_CYCLES-1, dp_out is sampled into rsp_result, rsp_id is loaded, rsp_valid goes to 1, and the FSM moves to RESP.
  - RESP. rsp_valid, rsp_id and rsp_result are held stable while rsp_ready=0. On the edge where rsp_valid && rsp_ready, rsp_valid goes to 0 and the FSM returns to IDLE. A new grant is possible in the cycle after that edge.
- Latency and throughput: accept edge at T; rsp_valid is high from T+SETTLE_CYCLES. Maximum throughput is one operation per SETTLE_CYCLES+2 cycles.
- dp_data/dp_select keep their last operands after a transaction; they are not re-zeroed.
- Requester withdrawing: a requester that drops req_valid before being granted is skipped, with no penalty.
- Same requester repeating: it is not re-granted while another requester is valid (fairness).
- Single active requester: that requester is granted back-to-back.
- Counter wrap: the settle counter clears on entry to DRIVE and never wraps past SETTLE_CYCLES-1.
- Reset mid-operation: the in-flight operation is discarded with no response, the FSM goes to IDLE, and the pointer returns to 0. The requester must reissue.

Optional Feature:
ENC_ARB_SWEEP_EN
- Defined: adds ports sweep_start (in, 1), sweep_done (out, 1) and sweep_sig (out, 3).
  - sweep_start is accepted in IDLE only and has priority over requesters.
  - The sweep issues 32 internal operations (data 0..15, each with select 0 then 1) through DRIVE with no RESP stall.
  - Each result is XOR-accumulated into sweep_sig, which clears at sweep start.
  - sweep_done pulses for 1 cycle after the last capture.
  - req_ready=0 during the sweep; busy=1.
- Not defined: the ports are absent and the block behaves exactly as above.

Decomposition:
- Package enc_arb_pkg holds:
  - state encoding IDLE/DRIVE/RESP (plus SWEEP under the macro);
  - DP_DATA_W=4 and DP_RES_W=3;
  - SWEEP_OPS=32.
- One natural sub-module: rr_arbiter (NUM_REQ request vector plus pointer in, one-hot grant and grant index out), purely combinational.

Test Plan:
In all scenarios, the bench stub returns dp_out = {dp_select, dp_data[1:0]}.
- Reset values: assert rst mid-DRIVE with req0 data=4'hA, select=1 → outputs zero immediately, no rsp_valid after release, pointer 0.
- Single request: req1 data=4'h6, select=0, rsp_ready=1, SETTLE_CYCLES=1 → req_ready[1] pulses once, rsp_valid at T+1 with rsp_id=1, rsp_result=3'b010.
- Round robin: all four valid continuously with data=i, select=1 → grant order 0,1,2,3,0; results 3'b100,3'b101,3'b110,3'b111.
- Backpressure: rsp_ready=0 for 5 cycles → rsp_valid/rsp_id/rsp_result stable; no req_ready pulses; on release, the next grant comes one cycle after the handshake.
- Settle window: SETTLE_CYCLES=3 → dp_data stable for 3 cycles; a dp_out glitch in the first 2 cycles is not captured.
- Sweep (ENC_ARB_SWEEP_EN): pulse sweep_start → 32 operations, sweep_done after 32*SETTLE_CYCLES+1 cycles, sweep_sig=3'b000 for the stub.
